// File: rtl/wave_capture_pkg.sv
// Shared types and defaults for the wave_capture triggered recorder.
package wave_capture_pkg;

    localparam int WC_DATA_WIDTH  = 8;
    localparam int WC_ADDR_WIDTH  = 8;
    localparam int WC_PRE_SAMPLES = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } wc_state_e;

    // Distance from the trigger sample back to the first sample of the record.
    function automatic int start_offset(input int pre_samples, input bit pretrig_en);
        return pretrig_en ? pre_samples : 0;
    endfunction

endpackage

// File: rtl/wave_capture_ram2port.sv
// Simple dual-port RAM: synchronous write port, registered read port.
// The array itself is never reset; only the read register is.
module ram2port #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [DATA_WIDTH-1:0] o_rdata
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Write port: store a sample when enabled.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Read port: registered; a read colliding with a write returns the old word.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/wave_capture.sv
// Triggered sample recorder. Waits for a rising crossing of i_level (or a
// forced trigger), stores one DEPTH-sample record and serves it back by
// logical index. Optional pre-trigger history: WAVE_CAPTURE_PRETRIG_EN.
module wave_capture
    import wave_capture_pkg::*;
#(
    parameter int DATA_WIDTH  = WC_DATA_WIDTH,
    parameter int ADDR_WIDTH  = WC_ADDR_WIDTH,
    parameter int PRE_SAMPLES = WC_PRE_SAMPLES
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [DATA_WIDTH-1:0] i_din,
    input  logic [DATA_WIDTH-1:0] i_level,
    input  logic                  i_arm,
    input  logic                  i_force,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [ADDR_WIDTH-1:0] o_trig_pos
);

`ifdef WAVE_CAPTURE_PRETRIG_EN
    localparam bit PRETRIG_ON = 1'b1;
`else
    localparam bit PRETRIG_ON = 1'b0;
`endif
    localparam logic [ADDR_WIDTH-1:0] START_OFF = ADDR_WIDTH'(start_offset(PRE_SAMPLES, PRETRIG_ON));
    localparam logic [ADDR_WIDTH-1:0] ONE_A     = ADDR_WIDTH'(1);

    wc_state_e             r_state;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_trig_pos;
    logic [DATA_WIDTH-1:0] r_prev;
    logic                  r_prev_valid;
    logic                  r_force_pend;
    logic                  r_busy;
    logic                  r_done;
`ifdef WAVE_CAPTURE_PRETRIG_EN
    logic [ADDR_WIDTH-1:0] r_fill;
`endif

    logic                  w_cross;
    logic                  w_qual;
    logic                  w_trig;
    logic                  w_last;
    logic                  w_wr_en;
    logic [ADDR_WIDTH-1:0] w_ptr_next;
    logic [ADDR_WIDTH-1:0] w_start;
    logic [ADDR_WIDTH-1:0] w_trig_start;
    logic [ADDR_WIDTH-1:0] w_rd_addr;

    // Trigger detection, end-of-record detection and address arithmetic.
    always_comb begin
        w_ptr_next   = r_wr_ptr + ONE_A;
        w_start      = r_trig_pos - START_OFF;
        w_trig_start = r_wr_ptr - START_OFF;
        w_rd_addr    = w_start + i_rd_addr;
        w_cross      = r_prev_valid && (r_prev < i_level) && (i_din >= i_level);
`ifdef WAVE_CAPTURE_PRETRIG_EN
        w_qual       = (r_fill >= START_OFF);
`else
        w_qual       = 1'b1;
`endif
        w_trig       = (r_state == ST_ARMED) && i_en && w_qual &&
                       (w_cross || r_force_pend || i_force);
        // The record ends with the write just below its start address; when
        // the trigger itself is that write, the record completes at once.
        w_last       = (r_state == ST_CAPTURE) ? (w_ptr_next == w_start)
                                               : (w_ptr_next == w_trig_start);
        case (r_state)
            ST_ARMED:   w_wr_en = PRETRIG_ON ? i_en : w_trig;
            ST_CAPTURE: w_wr_en = i_en;
            default:    w_wr_en = 1'b0;
        endcase
    end

    // Capture FSM with write pointer, history register and registered status.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_wr_ptr     <= '0;
            r_trig_pos   <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_force_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
`ifdef WAVE_CAPTURE_PRETRIG_EN
            r_fill       <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (i_arm) begin
                        r_state      <= ST_ARMED;
                        r_wr_ptr     <= '0;
                        r_prev_valid <= 1'b0;
                        r_force_pend <= 1'b0;
                        r_busy       <= 1'b1;
                        r_done       <= 1'b0;
`ifdef WAVE_CAPTURE_PRETRIG_EN
                        r_fill       <= '0;
`endif
                    end
                end
                ST_ARMED: begin
                    if (i_force) begin
                        r_force_pend <= 1'b1;
                    end
                    if (i_en) begin
                        r_prev       <= i_din;
                        r_prev_valid <= 1'b1;
                        if (w_trig) begin
                            r_trig_pos   <= r_wr_ptr;
                            r_wr_ptr     <= w_ptr_next;
                            r_force_pend <= 1'b0;
                            if (w_last) begin
                                r_state <= ST_DONE;
                                r_busy  <= 1'b0;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= ST_CAPTURE;
                            end
                        end else begin
`ifdef WAVE_CAPTURE_PRETRIG_EN
                            r_wr_ptr <= w_ptr_next;
                            if (r_fill < START_OFF) begin
                                r_fill <= r_fill + ONE_A;
                            end
`endif
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (i_en) begin
                        r_prev       <= i_din;
                        r_prev_valid <= 1'b1;
                        r_wr_ptr     <= w_ptr_next;
                        if (w_last) begin
                            r_state <= ST_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    ram2port #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr),
        .i_wdata (i_din),
        .i_raddr (w_rd_addr),
        .o_rdata (o_rd_data)
    );

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_trig_pos = r_trig_pos;

endmodule

// File: tb/tb_wave_capture.sv
// Self-checking bench for wave_capture: stream-level reference model plus
// hand-computed readback expectations for both build variants.
module tb_wave_capture;

    localparam int DEPTH = 256;
`ifdef WAVE_CAPTURE_PRETRIG_EN
    localparam int PRE = 128;
`else
    localparam int PRE = 0;
`endif

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] din;
    logic [7:0] level;
    logic       arm;
    logic       frc;
    logic [7:0] rd_addr;
    logic [7:0] rd_data;
    logic       busy;
    logic       done;
    logic [7:0] trig_pos;

    int checks = 0;
    int errors = 0;

    wave_capture dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_din      (din),
        .i_level    (level),
        .i_arm      (arm),
        .i_force    (frc),
        .i_rd_addr  (rd_addr),
        .o_rd_data  (rd_data),
        .o_busy     (busy),
        .o_done     (done),
        .o_trig_pos (trig_pos)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- reference model (operates on the accepted sample stream)
    int         m_mode;        // 0 idle, 1 waiting for trigger, 2 recording, 3 record ready
    int         m_trig_idx;
    int         m_trig_pos;
    bit         m_force_seen;
    bit         m_rd_ok;
    int         m_rd_q;
    int         m_n;
    bit         m_crossing;
    logic [7:0] m_stream [$];
    logic [7:0] m_rec [DEPTH];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode       = 0;
            m_trig_pos   = 0;
            m_rd_ok      = 1'b0;
            m_force_seen = 1'b0;
            m_stream.delete();
        end else begin
            m_rd_ok = (m_mode == 3);
            m_rd_q  = int'(rd_addr);
            if ((m_mode == 0 || m_mode == 3) && arm) begin
                m_mode       = 1;
                m_force_seen = 1'b0;
                m_stream.delete();
            end else if (m_mode == 1) begin
                if (frc) m_force_seen = 1'b1;
                if (en) begin
                    m_n        = m_stream.size();
                    m_crossing = (m_n > 0) && (m_stream[m_n-1] < level) && (din >= level);
                    m_stream.push_back(din);
                    if (m_n >= PRE && (m_crossing || m_force_seen)) begin
                        m_trig_idx = m_n;
                        m_trig_pos = (PRE > 0) ? (m_n % DEPTH) : 0;
                        m_mode     = 2;
                    end
                end
            end else if (m_mode == 2 && en) begin
                m_stream.push_back(din);
            end
            if (m_mode == 2 && m_stream.size() == m_trig_idx - PRE + DEPTH) begin
                for (int k = 0; k < DEPTH; k++) m_rec[k] = m_stream[m_trig_idx - PRE + k];
                m_mode = 3;
            end
        end
    end

    // Compare DUT outputs with the model on every falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            check("busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
            check("done", 32'(done), 32'(m_mode == 3));
            if (m_mode == 3) check("trig_pos", 32'(trig_pos), 32'(m_trig_pos));
            if (m_rd_ok) check("rd_data", 32'(rd_data), 32'(m_rec[m_rd_q]));
        end
    end

    // ---------------- stimulus helpers
    task automatic arm_pulse();
        @(negedge clk);
        arm = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        arm = 1'b0;
    endtask

    // Ramp 0,1,2.. presented every 'step' cycles; returns the cycle done was seen.
    task automatic run_ramp(input int step, input int arm_at, output int cyc);
        arm_pulse();
        cyc = 0;
        for (int c = 1; c <= 2000; c++) begin
            en  = ((c - 1) % step == 0);
            din = 8'((c - 1) / step);
            arm = (c == arm_at);
            @(negedge clk);
            if (done) begin
                cyc = c;
                break;
            end
        end
        en  = 1'b0;
        arm = 1'b0;
    endtask

    // One force pulse, then constant 0x10 samples; returns samples until done.
    task automatic run_force(input int max_samples, output int nsamp);
        frc = 1'b1;
        en  = 1'b0;
        @(negedge clk);
        frc   = 1'b0;
        nsamp = 0;
        for (int c = 0; c < max_samples; c++) begin
            en  = 1'b1;
            din = 8'h10;
            @(negedge clk);
            nsamp++;
            if (done) break;
        end
        en = 1'b0;
    endtask

    task automatic read_expect(input int addr, input int exp);
        rd_addr = 8'(addr);
        @(negedge clk);
        check($sformatf("read[%0d]", addr), 32'(rd_data), 32'(exp));
    endtask

    task automatic sweep_reads();
        for (int a = 0; a < DEPTH; a++) begin
            rd_addr = 8'(a);
            @(negedge clk);
        end
    endtask

    int cyc;
    int nsamp;

    initial begin
        rst = 1'b1; en = 1'b0; din = 8'd0; level = 8'd0;
        arm = 1'b0; frc = 1'b0; rd_addr = 8'd0;
        repeat (3) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_trig_pos", 32'(trig_pos), 32'd0);
        check("reset_rd_data", 32'(rd_data), 32'd0);
        rst = 1'b0;

`ifndef WAVE_CAPTURE_PRETRIG_EN
        // Ramp, en every cycle: trigger on sample 100, last sample 355.
        level = 8'd100;
        run_ramp(1, 0, cyc);
        check("ramp_done_cycle", 32'(cyc), 32'd356);
        check("ramp_trig_pos", 32'(trig_pos), 32'd0);
        read_expect(0, 100);
        read_expect(155, 255);
        read_expect(200, 44);
        sweep_reads();

        // Same ramp, en every other cycle.
        run_ramp(2, 0, cyc);
        check("ramp2_done_cycle", 32'(cyc), 32'd711);
        read_expect(0, 100);
        read_expect(155, 255);
        read_expect(200, 44);

        // arm pulsed mid-capture must be ignored.
        run_ramp(1, 200, cyc);
        check("armcap_done_cycle", 32'(cyc), 32'd356);
        read_expect(0, 100);
        read_expect(200, 44);
`else
        // Pre-trigger build: trigger on sample 200 with 128 samples of history.
        level = 8'd200;
        run_ramp(1, 0, cyc);
        check("pre_done_cycle", 32'(cyc), 32'd328);
        check("pre_trig_pos", 32'(trig_pos), 32'd200);
        read_expect(128, 200);
        read_expect(0, 72);
        read_expect(255, 71);
        sweep_reads();

        run_ramp(1, 250, cyc);
        check("armcap_done_cycle", 32'(cyc), 32'd328);
        read_expect(128, 200);
        read_expect(0, 72);
`endif

        // arm while DONE re-arms: done drops, busy rises.
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("rearm_done", 32'(done), 32'd0);
        check("rearm_busy", 32'(busy), 32'd1);

        // Forced trigger with no crossing possible.
        level = 8'hFF;
        run_force(400, nsamp);
        check("force_samples", 32'(nsamp), 32'd256);
        check("force_done", 32'(done), 32'd1);
        read_expect(0, 16);
        read_expect(128, 16);
        read_expect(255, 16);
        sweep_reads();

        // Asynchronous reset in the middle of a capture.
        arm_pulse();
        run_force(200, nsamp);
        check("midcap_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_trig_pos", 32'(trig_pos), 32'd0);
        check("async_rd_data", 32'(rd_data), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
